seg_display_arbiter: RTL

- Shares the single 7-segment output between N_REQ digit sources; each source is a counter, status or debug value wanting display time.
- Grants are round-robin, and each grant holds the display for a minimum dwell time.
- The granted 4-bit value is decoded to hex segments on registered outputs.
- Sits between the design's digit producers and io_out[6:0].

---
 rtl/seg_display_pkg.sv | 19 +
 rtl/seg_display_arbiter_hex_to_seg7.sv | 11 +
 rtl/seg_display_arbiter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/seg_display_pkg.sv
// Shared types and constants for the 7-segment display arbiter and its hex decoder.
package seg_display_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Segment order {g,f,e,d,c,b,a}, active-high; entry 15 is listed first.
    localparam logic [15:0][6:0] HEX_SEG_TBL = {
        7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
        7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
        7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
        7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
    };

endpackage

// File: rtl/seg_display_arbiter_hex_to_seg7.sv
// Combinational hex nibble to 7-segment decoder, shared with other display blocks.
module hex_to_seg7
    import seg_display_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = HEX_SEG_TBL[i_nibble];

endmodule

// File: rtl/seg_display_arbiter.sv
// Round-robin arbiter sharing one 7-segment display among N_REQ digit sources,
// with a minimum dwell per grant. Optional SEG_ARB_PRIORITY_EN makes source 0 preemptive.
module seg_display_arbiter
    import seg_display_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int HOLD_CYCLES = 1000,
    parameter int CNT_W       = $clog2(HOLD_CYCLES + 1)
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [4*N_REQ-1:0]   digit,
    output logic [N_REQ-1:0]     grant,
    output logic                 active,
    output logic                 switch_pulse,
    output logic [6:0]           segments
);

    localparam int               IDX_W        = $clog2(N_REQ);
    localparam logic [CNT_W-1:0] DWELL_RELOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(N_REQ - 1);

    state_t             r_state;
    logic [N_REQ-1:0]   r_grant;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic               r_active;
    logic               r_pulse;
    logic [CNT_W-1:0]   r_dwell;
    logic [6:0]         r_seg;

    logic [N_REQ-1:0]   w_cand;
    logic [IDX_W-1:0]   w_start;
    logic [IDX_W-1:0]   w_pick;
    logic [IDX_W-1:0]   w_pick_nxt;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [N_REQ-1:0]   w_pick_oh;
    logic               w_found;
    logic               w_keep0;
    logic [3:0]         w_nibble;
    logic [6:0]         w_seg;

    assign w_idx_nxt  = (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
    assign w_pick_nxt = (w_pick == LAST_IDX) ? '0 : w_pick + 1'b1;
    assign w_pick_oh  = N_REQ'(1) << w_pick;

`ifdef SEG_ARB_PRIORITY_EN
    // Source 0 keeps the display through dwell expiry for as long as it requests.
    assign w_keep0 = (r_idx == '0);
`else
    assign w_keep0 = 1'b0;
`endif

    // Idle searches from rr_ptr; while holding, search the others starting after the holder.
    always_comb begin
        w_cand  = req;
        w_start = r_rr_ptr;
        if (r_state == HOLD) begin
            w_cand  = req & ~r_grant;
            w_start = w_idx_nxt;
        end
    end

    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            int j;
            j = int'(w_start) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (!w_found && w_cand[IDX_W'(j)]) begin
                w_found = 1'b1;
                w_pick  = IDX_W'(j);
            end
        end
    end

    // Digit is picked live every cycle, so source value changes show with 1-cycle latency.
    always_comb begin
        w_nibble = '0;
        for (int k = 0; k < N_REQ; k++)
            if (r_idx == IDX_W'(k)) w_nibble = digit[4*k +: 4];
    end

    hex_to_seg7 u_dec (
        .i_nibble (w_nibble),
        .o_seg    (w_seg)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_idx    <= '0;
            r_rr_ptr <= '0;
            r_active <= 1'b0;
            r_pulse  <= 1'b0;
            r_dwell  <= '0;
            r_seg    <= SEG_BLANK;
        end else begin
            r_pulse <= 1'b0;
            r_seg   <= r_active ? w_seg : SEG_BLANK;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state  <= HOLD;
                        r_grant  <= w_pick_oh;
                        r_idx    <= w_pick;
                        r_active <= 1'b1;
                        r_pulse  <= 1'b1;
                        r_dwell  <= DWELL_RELOAD;
                        r_rr_ptr <= w_pick_nxt;
                    end
                end
                HOLD: begin
`ifdef SEG_ARB_PRIORITY_EN
                    if (req[0] && r_idx != '0) begin
                        r_grant <= N_REQ'(1);
                        r_idx   <= '0;
                        r_pulse <= 1'b1;
                        r_dwell <= DWELL_RELOAD;
                    end else
`endif
                    if (!req[r_idx]) begin
                        if (w_found) begin
                            r_grant  <= w_pick_oh;
                            r_idx    <= w_pick;
                            r_pulse  <= 1'b1;
                            r_dwell  <= DWELL_RELOAD;
                            r_rr_ptr <= w_pick_nxt;
                        end else begin
                            r_state  <= IDLE;
                            r_grant  <= '0;
                            r_active <= 1'b0;
                            r_dwell  <= '0;
                        end
                    end else if (r_dwell != '0) begin
                        r_dwell <= r_dwell - 1'b1;
                    end else if (w_found && !w_keep0) begin
                        r_grant  <= w_pick_oh;
                        r_idx    <= w_pick;
                        r_pulse  <= 1'b1;
                        r_dwell  <= DWELL_RELOAD;
                        r_rr_ptr <= w_pick_nxt;
                    end else begin
                        r_dwell <= DWELL_RELOAD;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign grant        = r_grant;
    assign active       = r_active;
    assign switch_pulse = r_pulse;
    assign segments     = r_seg;

endmodule
